// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential req/ack fetch into a circular {pc, inst} buffer, flushed on redirect.
// Optional INST_PREFETCH_STATS_EN adds saturating stat_fetched / stat_flushed counters.
module inst_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     deq,
  output logic                     q_valid,
  output logic [31:0]              q_inst,
  output logic [31:0]              q_pc,
  output logic [31:0]              q_pc4,
  output logic [$clog2(DEPTH):0]   q_count
`ifdef INST_PREFETCH_STATS_EN
  ,
  output logic [31:0]              stat_fetched,
  output logic [31:0]              stat_flushed
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN} state_e;

  state_e         state_q, state_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [31:0]    addr_q, addr_d;
  logic           req_q;
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic [31:0]    mem_inst [DEPTH];
  logic [31:0]    mem_pc   [DEPTH];
  logic           push, pop;

  // Fetch sequencing; a request, once raised, is held until its ack
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!redirect && (count_q < CW'(DEPTH))) begin
          state_d = ST_FETCH;
          addr_d  = fetch_pc_q;
        end
      end
      ST_FETCH: begin
        if (imem_ack) begin
          state_d = ST_IDLE;
          if (!redirect) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (redirect) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (imem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (redirect) fetch_pc_d = redirect_pc & ~32'h3;
  end

  // Queue pointers; redirect empties the queue and ignores deq/push
  always_comb begin
    pop     = deq && (count_q != '0) && !redirect;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + PW'(1);
      if (push) tail_d = tail_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= (state_d != ST_IDLE);
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q
  always_ff @(posedge Clock) begin
    if (push) begin
      mem_inst[tail_q] <= imem_rdata;
      mem_pc[tail_q]   <= addr_q;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign q_valid   = (count_q != '0);
  assign q_count   = count_q;
  assign q_inst    = mem_inst[head_q];
  assign q_pc      = mem_pc[head_q];
  assign q_pc4     = mem_pc[head_q] + 32'd4;

`ifdef INST_PREFETCH_STATS_EN
  logic [31:0] fetched_q, flushed_q;
  logic        drop_ack;
  logic [CW:0] flush_inc;
  logic [32:0] flush_sum;

  // Discarded entries: queue contents on redirect plus any ack whose data is dropped
  always_comb begin
    drop_ack  = imem_ack && (((state_q == ST_FETCH) && redirect) || (state_q == ST_DRAIN));
    flush_inc = (redirect ? {1'b0, count_q} : '0) + (CW + 1)'(drop_ack);
    flush_sum = 33'(flushed_q) + 33'(flush_inc);
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      if (push && (fetched_q != '1)) fetched_q <= fetched_q + 32'd1;
      flushed_q <= flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_flushed = flushed_q;
`endif

endmodule
